game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//  Top-level frame scheduler for J.O.S.H. Jump. Sits between the board inputs
//  (go/gravity keys) and the game datapath + screen updater. Runs the menu ->
//  game -> game-over flow, generates the frame tick and sequences one datapath
//  step then one screen redraw per tick via req/done handshakes. Keeps the score.
// PARAMETERS
//  TICK_DIV  833333  clk cycles per frame tick (60 Hz @ 50 MHz); must be >= 2
//  SCORE_W   8       score width; score saturates at 2**SCORE_W-1
// PORTS
//  clk        in   1        system clock (CLOCK_50)
//  reset      in   1        asynchronous, active-high reset
//  go         in   1        start key level, already synchronised, 1 = pressed
//  grav_btn   in   1        gravity key level, already synchronised, 1 = pressed
//  endgame    in   1        datapath collision flag; valid only with step_done
//  step_done  in   1        datapath finished the requested step (1-cycle pulse)
//  draw_done  in   1        screen updater finished the redraw (1-cycle pulse)
//  startgame  out  1        1 while in any game state (INIT..DRAW, PAUSE)
//  init_req   out  1        1-cycle pulse: datapath reloads walls/dude
//  step_req   out  1        level, held until step_done is seen
//  draw_req   out  1        level, held until draw_done is seen
//  grav       out  1        gravity direction to datapath, 0 = down, 1 = up
//  score      out  SCORE_W  frames survived (to HEX0/HEX1)
//  state_dbg  out  3        current state encoding (to LEDR)
// BEHAVIOUR
//  Reset (async, any state): state=MENU; all outputs 0; tick counter, pending
//   flag and gravity-edge register cleared.
//  States/transitions (registered, 1 cycle each unless noted):
//   MENU: go=1 -> MENU_WAIT.  MENU_WAIT: go=0 -> INIT (waits for key release).
//   INIT: init_req=1, score<=0, grav<=0, tick counter<=0 -> WAIT_TICK.
//   WAIT_TICK: tick (or pending) -> STEP.
//   STEP: step_req=1; on step_done: endgame=0 -> score+1 (saturating), DRAW;
//         endgame=1 -> score held, over flag set, DRAW.
//   DRAW: draw_req=1; on draw_done: over ? OVER : (pending ? STEP : WAIT_TICK).
//   OVER: startgame=0, score held; go=1 -> MENU_WAIT (new game after release).
//  Tick: counter 0..TICK_DIV-1 runs only while startgame=1; tick = 1-cycle
//   pulse on wrap. Tick seen outside WAIT_TICK sets pending (1 deep); a further
//   tick while pending is dropped. Pending cleared on entry to STEP.
//  Gravity: rising edge of grav_btn toggles a shadow bit; grav <= shadow on
//   entry to STEP only (stable for a whole step). Edges outside game states ignored.
//  Simultaneous: step_done and tick same cycle -> both honoured (pending set).
//   endgame without step_done is ignored. go during game states ignored.
//  req signals drop in the cycle after the matching done; done while req=0 ignored.
// CONFIGURATION
//  JOSH_PAUSE_EN defined: extra input port `pause` (1, synchronised level).
//   In WAIT_TICK with pause=1 -> PAUSE; tick counter frozen, pending kept;
//   pause=0 -> WAIT_TICK. pause ignored in all other states; startgame stays 1.
//  Not defined: no pause port, PAUSE state unencoded, counter never frozen.
// STRUCTURE
//  Shared package josh_pkg: state localparams (MENU=0 .. OVER, PAUSE), grav
//   direction constants, default TICK_DIV/SCORE_W.
//  One sub-module: frame_tick_gen (enable, clear, freeze -> tick pulse).
//  FSM, pending flag, gravity edge/shadow and score stay in this module.
// TESTING (TICK_DIV=4, SCORE_W=4)
//  Reset mid-STEP -> next cycle state_dbg=MENU, step_req=0, score=0, grav=0.
//  go 1 for 3 cycles then 0 -> init_req one pulse, then step_req 4 cycles later.
//  10 steps with done, endgame=0 -> score=10; 20 steps -> score saturates at 15.
//  draw_done delayed 6 cycles -> pending set; next STEP entered right after
//   draw_done; extra tick in the window dropped (exactly one extra step).
//  grav_btn edge mid-STEP -> grav unchanged until next STEP entry, then 1.
//  step_done+endgame=1 at score=7 -> one DRAW, OVER, score=7, startgame=0;
//   with JOSH_PAUSE_EN, pause=1 in WAIT_TICK for 20 cycles -> no step_req.

Source files
------------

// File: rtl/josh_pkg.sv
// Shared state encoding, gravity constants and default sizing for the J.O.S.H. Jump sequencer.
// ST_PAUSE exists only when JOSH_PAUSE_EN is defined.
package josh_pkg;

  localparam int TICK_DIV_DEF = 833333;
  localparam int SCORE_W_DEF  = 8;

  localparam logic GRAV_DOWN = 1'b0;
  localparam logic GRAV_UP   = 1'b1;

  typedef enum logic [2:0] {
    ST_MENU      = 3'd0,
    ST_MENU_WAIT = 3'd1,
    ST_INIT      = 3'd2,
    ST_WAIT_TICK = 3'd3,
    ST_STEP      = 3'd4,
    ST_DRAW      = 3'd5,
    ST_OVER      = 3'd6
`ifdef JOSH_PAUSE_EN
    , ST_PAUSE   = 3'd7
`endif
  } state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame divider: counts 0..TICK_DIV-1 while enabled, one-cycle tick on wrap.
// clear zeroes the count, freeze holds it; neither produces a tick.
module frame_tick_gen
  import josh_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = enable && !clear && !freeze && (cnt == LAST);

endmodule

// File: rtl/game_sequencer.sv
// Frame scheduler for J.O.S.H. Jump: menu/game/over flow, one step then one redraw per frame tick.
// Define JOSH_PAUSE_EN to add the pause input and PAUSE state.
module game_sequencer
  import josh_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int SCORE_W  = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               grav_btn,
`ifdef JOSH_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               endgame,
  input  logic               step_done,
  input  logic               draw_done,
  output logic               startgame,
  output logic               init_req,
  output logic               step_req,
  output logic               draw_req,
  output logic               grav,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         state_dbg
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t state, state_nx;
  logic   tick, freeze, enter_step;
  logic   pending, over, grav_q, shadow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_MENU;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    startgame = 1'b0;
    init_req  = 1'b0;
    step_req  = 1'b0;
    draw_req  = 1'b0;
    case (state)
      ST_MENU:      if (go) state_nx = ST_MENU_WAIT;
      ST_MENU_WAIT: if (!go) state_nx = ST_INIT;
      ST_INIT: begin
        startgame = 1'b1;
        init_req  = 1'b1;
        state_nx  = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        startgame = 1'b1;
`ifdef JOSH_PAUSE_EN
        if (pause)                state_nx = ST_PAUSE;
        else if (tick || pending) state_nx = ST_STEP;
`else
        if (tick || pending) state_nx = ST_STEP;
`endif
      end
      ST_STEP: begin
        startgame = 1'b1;
        step_req  = 1'b1;
        if (step_done) state_nx = ST_DRAW;
      end
      ST_DRAW: begin
        startgame = 1'b1;
        draw_req  = 1'b1;
        if (draw_done) state_nx = over ? ST_OVER : (pending ? ST_STEP : ST_WAIT_TICK);
      end
      ST_OVER:      if (go) state_nx = ST_MENU_WAIT;
`ifdef JOSH_PAUSE_EN
      ST_PAUSE: begin
        startgame = 1'b1;
        if (!pause) state_nx = ST_WAIT_TICK;
      end
`endif
      default:      state_nx = ST_MENU;
    endcase
  end

  assign state_dbg  = state;
  assign enter_step = (state_nx == ST_STEP) && (state != ST_STEP);

`ifdef JOSH_PAUSE_EN
  assign freeze = (state == ST_PAUSE);
`else
  assign freeze = 1'b0;
`endif

  frame_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (reset),
    .enable (startgame),
    .clear  (state == ST_INIT),
    .freeze (freeze),
    .tick   (tick)
  );

  // A tick that does not launch a step right away is remembered once; extras are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            pending <= 1'b0;
    else if (state == ST_INIT || enter_step) pending <= 1'b0;
    else if (tick)                        pending <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      over  <= 1'b0;
      score <= '0;
    end else if (state == ST_INIT) begin
      over  <= 1'b0;
      score <= '0;
    end else if (state == ST_STEP && step_done) begin
      if (endgame)                 over  <= 1'b1;
      else if (score != SCORE_MAX) score <= score + SCORE_W'(1);
    end
  end

  // Key presses toggle a shadow bit; the datapath only sees it at step boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grav_q <= 1'b0;
      shadow <= 1'b0;
      grav   <= GRAV_DOWN;
    end else begin
      grav_q <= grav_btn;
      if (state == ST_INIT) begin
        shadow <= 1'b0;
        grav   <= GRAV_DOWN;
      end else begin
        if (startgame && grav_btn && !grav_q) shadow <= ~shadow;
        if (enter_step) grav <= shadow ? GRAV_UP : GRAV_DOWN;
      end
    end
  end

endmodule
